// File: rtl/sensor_request_ctrl.sv
// Host request controller: takes {addr, cmd} frames from UART RX, runs one sensor
// measurement with checksum and timeout, and answers with a {code, data} reply.
//
// state    | meaning
// IDLE     | waiting for an address byte or a pending continuous re-measure
// RX_CMD   | address latched, waiting for the command byte (gap-limited)
// DECODE   | classify address/command, update continuous slot
// START    | o_sensor_start pulse
// WAIT     | waiting for i_sensor_done (timeout-limited)
// EVAL     | checksum/timeout evaluation, build reply
// TX_B0    | o_tx_start pulse for the response code
// WAIT_B0  | waiting for i_tx_done of the code byte
// TX_B1    | o_tx_start pulse for the data byte
// WAIT_B1  | waiting for i_tx_done of the data byte
module sensor_request_ctrl #(
  parameter int N_SENSORS      = 32,
  parameter int ADDR_W         = 5,
  parameter int PERIOD_CYCLES  = 50_000_000,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int RX_GAP_CYCLES  = 500_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_done,
  output logic [ADDR_W-1:0] o_sensor_sel,
  output logic              o_sensor_start,
  input  logic              i_sensor_done,
  input  logic [39:0]       i_sensor_data,
  output logic              o_busy,
  output logic              o_cont_active,
  output logic              o_drop
);

  typedef enum logic [3:0] {
    S_IDLE, S_RX_CMD, S_DECODE, S_START, S_WAIT,
    S_EVAL, S_TX_B0, S_WAIT_B0, S_TX_B1, S_WAIT_B1
  } state_t;

  typedef enum logic [1:0] {K_STATUS, K_TEMP, K_HUM} kind_t;

  localparam logic [8:0]  ADDR_LIM    = 9'(N_SENSORS);
  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST    = 32'(RX_GAP_CYCLES - 1);

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [39:0]       data_q, data_d;
  logic              tmo_q, tmo_d;
  logic [31:0]       timer_q, timer_d;
  logic [7:0]        resp_q, resp_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic              sensor_start_q, sensor_start_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;
  logic              cont_active_q, cont_active_d;
  logic [ADDR_W-1:0] cont_addr_q, cont_addr_d;
  logic              cont_hum_q, cont_hum_d;
  logic              pend_q, pend_d;
  logic [31:0]       period_q, period_d;

  logic       wrap;
  logic       addr_ok;
  logic [7:0] sum8;
  logic       crc_ok;

  assign wrap    = cont_active_q && (period_q == PERIOD_LAST);
  assign addr_ok = {1'b0, addr_q} < ADDR_LIM;
  assign sum8    = data_q[39:32] + data_q[31:24] + data_q[23:16] + data_q[15:8];
  assign crc_ok  = (sum8 == data_q[7:0]);

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    addr_d         = addr_q;
    cmd_d          = cmd_q;
    data_d         = data_q;
    tmo_d          = tmo_q;
    timer_d        = timer_q;
    resp_d         = resp_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    sel_d          = sel_q;
    sensor_start_d = 1'b0;
    cont_active_d  = cont_active_q;
    cont_addr_d    = cont_addr_q;
    cont_hum_d     = cont_hum_q;
    period_d       = period_q;
    pend_d         = pend_q | wrap;
    drop_d         = i_rx_valid && (state_q != S_IDLE) && (state_q != S_RX_CMD);

    if (cont_active_q) period_d = wrap ? 32'd0 : period_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        // A host frame takes priority; a pending re-measure waits for the next IDLE.
        if (i_rx_valid) begin
          addr_d  = i_rx_data;
          timer_d = GAP_LAST;
          state_d = S_RX_CMD;
        end else if (pend_q) begin
          sel_d          = cont_addr_q;
          kind_d         = cont_hum_q ? K_HUM : K_TEMP;
          sensor_start_d = 1'b1;
          pend_d         = wrap;
          state_d        = S_START;
        end
      end
      S_RX_CMD: begin
        if (i_rx_valid) begin
          cmd_d   = i_rx_data;
          state_d = S_DECODE;
        end else if (timer_q == 32'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_DECODE: begin
        state_d    = S_TX_B0;
        tx_start_d = 1'b1;
        resp_d     = 8'h00;
        tx_data_d  = 8'h00;
        if (!addr_ok) begin
          tx_data_d = 8'hEE;
          resp_d    = addr_q;
        end else begin
          case (cmd_q)
            8'h03, 8'h04, 8'h05, 8'h06, 8'h07: begin
              tx_start_d     = 1'b0;
              sensor_start_d = 1'b1;
              sel_d          = addr_q[ADDR_W-1:0];
              state_d        = S_START;
              kind_d         = (cmd_q == 8'h03) ? K_STATUS :
                               (cmd_q == 8'h04 || cmd_q == 8'h06) ? K_TEMP : K_HUM;
              if (cmd_q == 8'h06 || cmd_q == 8'h07) begin
                cont_active_d = 1'b1;
                cont_addr_d   = addr_q[ADDR_W-1:0];
                cont_hum_d    = (cmd_q == 8'h07);
                period_d      = 32'd0;
                pend_d        = 1'b0;
              end
            end
            8'h08, 8'h09: begin
              tx_data_d = (cmd_q == 8'h08) ? 8'h0A : 8'h0B;
              if (cont_active_q && (cont_hum_q == (cmd_q == 8'h09))) begin
                cont_active_d = 1'b0;
                period_d      = 32'd0;
                pend_d        = 1'b0;
              end
            end
            default: begin
              tx_data_d = 8'hEF;
              resp_d    = cmd_q;
            end
          endcase
        end
      end
      S_START: begin
        timer_d = TMO_LAST;
        tmo_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_sensor_done) begin
          data_d  = i_sensor_data;
          state_d = S_EVAL;
        end else if (timer_q == 32'd0) begin
          tmo_d   = 1'b1;
          state_d = S_EVAL;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_EVAL: begin
        state_d    = S_TX_B0;
        tx_start_d = 1'b1;
        if (tmo_q || !crc_ok) begin
          tx_data_d = 8'h1F;
          resp_d    = 8'h00;
        end else begin
          case (kind_q)
            K_TEMP:  begin tx_data_d = 8'h08; resp_d = data_q[23:16]; end
            K_HUM:   begin tx_data_d = 8'h09; resp_d = data_q[39:32]; end
            default: begin tx_data_d = 8'h07; resp_d = 8'h00;         end
          endcase
        end
      end
      S_TX_B0: state_d = S_WAIT_B0;
      S_WAIT_B0: begin
        if (i_tx_done) begin
          tx_data_d  = resp_q;
          tx_start_d = 1'b1;
          state_d    = S_TX_B1;
        end
      end
      S_TX_B1: state_d = S_WAIT_B1;
      S_WAIT_B1: if (i_tx_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      kind_q         <= K_STATUS;
      addr_q         <= '0;
      cmd_q          <= '0;
      data_q         <= '0;
      tmo_q          <= 1'b0;
      timer_q        <= '0;
      resp_q         <= '0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      sel_q          <= '0;
      sensor_start_q <= 1'b0;
      busy_q         <= 1'b0;
      drop_q         <= 1'b0;
      cont_active_q  <= 1'b0;
      cont_addr_q    <= '0;
      cont_hum_q     <= 1'b0;
      pend_q         <= 1'b0;
      period_q       <= '0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      addr_q         <= addr_d;
      cmd_q          <= cmd_d;
      data_q         <= data_d;
      tmo_q          <= tmo_d;
      timer_q        <= timer_d;
      resp_q         <= resp_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      sel_q          <= sel_d;
      sensor_start_q <= sensor_start_d;
      busy_q         <= busy_d;
      drop_q         <= drop_d;
      cont_active_q  <= cont_active_d;
      cont_addr_q    <= cont_addr_d;
      cont_hum_q     <= cont_hum_d;
      pend_q         <= pend_d;
      period_q       <= period_d;
    end
  end

  assign o_tx_data      = tx_data_q;
  assign o_tx_start     = tx_start_q;
  assign o_sensor_sel   = sel_q;
  assign o_sensor_start = sensor_start_q;
  assign o_busy         = busy_q;
  assign o_cont_active  = cont_active_q;
  assign o_drop         = drop_q;

endmodule

// File: tb/tb_sensor_request_ctrl.sv
// Directed bench for sensor_request_ctrl with shortened period/timeout/gap constants.
module tb_sensor_request_ctrl;

  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 50;
  localparam int GAP     = 30;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done = 1'b0;
  logic [4:0]  o_sensor_sel;
  logic        o_sensor_start;
  logic        i_sensor_done = 1'b0;
  logic [39:0] i_sensor_data = 40'h0;
  logic        o_busy;
  logic        o_cont_active;
  logic        o_drop;

  int n_pass  = 0;
  int n_total = 0;
  int n_sstart = 0;
  int cyc_cnt = 0;

  sensor_request_ctrl #(
    .N_SENSORS(32), .ADDR_W(5), .PERIOD_CYCLES(PERIOD),
    .TIMEOUT_CYCLES(TIMEOUT), .RX_GAP_CYCLES(GAP)
  ) dut (
    .clock(clock), .reset(reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_sensor_sel(o_sensor_sel), .o_sensor_start(o_sensor_start),
    .i_sensor_done(i_sensor_done), .i_sensor_data(i_sensor_data),
    .o_busy(o_busy), .o_cont_active(o_cont_active), .o_drop(o_drop)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt++;
  always @(negedge clock) if (o_sensor_start) n_sstart++;

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    i_rx_data = b; i_rx_valid = 1'b1;
    @(posedge clock); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c);
    send_byte(a);
    send_byte(c);
  endtask

  task automatic wait_sensor_start(output bit seen, output int cyc, input int limit);
    cyc = 0;
    while (!o_sensor_start && cyc < limit) begin
      @(posedge clock); #1; cyc++;
    end
    seen = o_sensor_start;
  endtask

  task automatic wait_tx(output bit seen, output int cyc, input int limit);
    cyc = 0;
    while (!o_tx_start && cyc < limit) begin
      @(posedge clock); #1; cyc++;
    end
    seen = o_tx_start;
  endtask

  task automatic pulse_sensor_done(input logic [39:0] d);
    @(posedge clock); #1;
    i_sensor_data = d; i_sensor_done = 1'b1;
    @(posedge clock); #1;
    i_sensor_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(posedge clock); #1;
    i_tx_done = 1'b1;
    @(posedge clock); #1;
    i_tx_done = 1'b0;
  endtask

  // Captures both reply bytes; lat is cycles to the first o_tx_start.
  task automatic get_reply(output bit ok, output logic [7:0] b0, output logic [7:0] b1,
                           output int lat);
    bit s;
    int c;
    wait_tx(s, c, TIMEOUT + 20);
    ok = s; lat = c; b0 = o_tx_data;
    pulse_tx_done();
    wait_tx(s, c, 10);
    ok = ok & s; b1 = o_tx_data;
    pulse_tx_done();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    n_total++;
    if ({o_tx_data, o_tx_start, o_sensor_sel, o_sensor_start, o_busy, o_cont_active, o_drop} !== 19'd0)
      $display("FAIL reset_outputs got %h want 0",
               {o_tx_data, o_tx_start, o_sensor_sel, o_sensor_start, o_busy, o_cont_active, o_drop});
    else n_pass++;
  endtask

  task automatic test_temp_read();
    bit s, ok; int c, lat; logic [7:0] b0, b1;
    send_frame(8'h02, 8'h04);
    wait_sensor_start(s, c, 10);
    n_total++; if (c !== 1) $display("FAIL t1_start_latency got %0d want 1", c); else n_pass++;
    n_total++; if (o_sensor_sel !== 5'd2) $display("FAIL t1_sel got %0d want 2", o_sensor_sel); else n_pass++;
    n_total++; if (o_busy !== 1'b1) $display("FAIL t1_busy got %b want 1", o_busy); else n_pass++;
    @(posedge clock); #1;
    n_total++; if (o_sensor_start !== 1'b0) $display("FAIL t1_start_width got %b want 0", o_sensor_start); else n_pass++;
    pulse_sensor_done(40'h28_00_19_00_41);
    get_reply(ok, b0, b1, lat);
    n_total++; if (!ok || lat !== 1) $display("FAIL t1_tx_latency got %0d (ok=%b) want 1", lat, ok); else n_pass++;
    n_total++; if (b0 !== 8'h08) $display("FAIL t1_code got %h want 08", b0); else n_pass++;
    n_total++; if (b1 !== 8'h19) $display("FAIL t1_data got %h want 19", b1); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL t1_idle got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_checksum();
    bit s, ok; int c, lat; logic [7:0] b0, b1;
    send_frame(8'h01, 8'h03);
    wait_sensor_start(s, c, 10);
    pulse_sensor_done(40'h28_00_19_00_40);
    get_reply(ok, b0, b1, lat);
    n_total++; if (!ok || b0 !== 8'h1F || b1 !== 8'h00)
      $display("FAIL crc_bad got %h %h (ok=%b) want 1f 00", b0, b1, ok); else n_pass++;
    send_frame(8'h01, 8'h03);
    wait_sensor_start(s, c, 10);
    pulse_sensor_done(40'h80_80_05_00_05);
    get_reply(ok, b0, b1, lat);
    n_total++; if (!ok || b0 !== 8'h07 || b1 !== 8'h00)
      $display("FAIL crc_wrap got %h %h (ok=%b) want 07 00", b0, b1, ok); else n_pass++;
  endtask

  task automatic test_bad_frames();
    bit ok; int lat, n0; logic [7:0] b0, b1;
    logic [7:0] addrs [4] = '{8'h25, 8'h01, 8'h20, 8'h1F};
    logic [7:0] cmds  [4] = '{8'h0C, 8'h0C, 8'h09, 8'h02};
    logic [7:0] exp0  [4] = '{8'hEE, 8'hEF, 8'hEE, 8'hEF};
    logic [7:0] exp1  [4] = '{8'h25, 8'h0C, 8'h20, 8'h02};
    for (int i = 0; i < 4; i++) begin
      n0 = n_sstart;
      send_frame(addrs[i], cmds[i]);
      get_reply(ok, b0, b1, lat);
      n_total++; if (!ok || lat !== 1 || b0 !== exp0[i] || b1 !== exp1[i])
        $display("FAIL bad_frame%0d got %h %h lat=%0d want %h %h lat=1", i, b0, b1, lat, exp0[i], exp1[i]);
      else n_pass++;
      n_total++; if (n_sstart !== n0) $display("FAIL bad_frame%0d_nostart got %0d starts want 0", i, n_sstart - n0);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit s, ok; int c, lat; logic [7:0] b0, b1;
    send_frame(8'h04, 8'h04);
    wait_sensor_start(s, c, 10);
    get_reply(ok, b0, b1, lat);
    n_total++; if (!ok || lat !== TIMEOUT + 2) $display("FAIL tmo_latency got %0d want %0d", lat, TIMEOUT + 2);
    else n_pass++;
    n_total++; if (b0 !== 8'h1F || b1 !== 8'h00) $display("FAIL tmo_reply got %h %h want 1f 00", b0, b1); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL tmo_idle got %b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_rx_gap();
    send_byte(8'h02);
    repeat (GAP - 1) @(posedge clock);
    #1;
    n_total++; if (o_busy !== 1'b1) $display("FAIL gap_still_busy got %b want 1", o_busy); else n_pass++;
    @(posedge clock); #1;
    n_total++; if (o_busy !== 1'b0) $display("FAIL gap_abandon got %b want 0", o_busy); else n_pass++;
    n_total++; if (o_tx_start !== 1'b0) $display("FAIL gap_silent got %b want 0", o_tx_start); else n_pass++;
  endtask

  task automatic test_continuous();
    bit s, ok; int c, lat, n0; int t [3]; logic [7:0] b0, b1;
    send_frame(8'h03, 8'h07);
    for (int k = 0; k < 3; k++) begin
      wait_sensor_start(s, c, PERIOD + 50);
      t[k] = cyc_cnt;
      n_total++; if (!s || o_sensor_sel !== 5'd3) $display("FAIL cont_start%0d got seen=%b sel=%0d want 1 3", k, s, o_sensor_sel);
      else n_pass++;
      pulse_sensor_done(40'h30_00_15_00_45);
      get_reply(ok, b0, b1, lat);
      n_total++; if (!ok || b0 !== 8'h09 || b1 !== 8'h30)
        $display("FAIL cont_reply%0d got %h %h want 09 30", k, b0, b1); else n_pass++;
    end
    n_total++; if (o_cont_active !== 1'b1) $display("FAIL cont_active got %b want 1", o_cont_active); else n_pass++;
    n_total++; if (t[2] - t[1] !== PERIOD) $display("FAIL cont_period got %0d want %0d", t[2] - t[1], PERIOD);
    else n_pass++;
    send_frame(8'h03, 8'h08);
    get_reply(ok, b0, b1, lat);
    n_total++; if (!ok || lat !== 1 || b0 !== 8'h0A || b1 !== 8'h00)
      $display("FAIL cont_off_mismatch got %h %h want 0a 00", b0, b1); else n_pass++;
    n_total++; if (o_cont_active !== 1'b1) $display("FAIL cont_kept got %b want 1", o_cont_active); else n_pass++;
    send_frame(8'h03, 8'h09);
    get_reply(ok, b0, b1, lat);
    n_total++; if (!ok || lat !== 1 || b0 !== 8'h0B || b1 !== 8'h00)
      $display("FAIL cont_off got %h %h want 0b 00", b0, b1); else n_pass++;
    n_total++; if (o_cont_active !== 1'b0) $display("FAIL cont_cleared got %b want 0", o_cont_active); else n_pass++;
    n0 = n_sstart;
    repeat (2 * PERIOD + 50) @(posedge clock);
    #1;
    n_total++; if (n_sstart !== n0) $display("FAIL cont_silent got %0d starts want 0", n_sstart - n0); else n_pass++;
  endtask

  task automatic test_drop_and_reset();
    bit s, ok; int c, lat; logic [7:0] b0, b1;
    send_frame(8'h02, 8'h04);
    wait_sensor_start(s, c, 10);
    send_byte(8'h55);
    n_total++; if (o_drop !== 1'b1) $display("FAIL drop_pulse got %b want 1", o_drop); else n_pass++;
    @(posedge clock); #1;
    n_total++; if (o_drop !== 1'b0) $display("FAIL drop_width got %b want 0", o_drop); else n_pass++;
    pulse_sensor_done(40'h28_00_19_00_41);
    get_reply(ok, b0, b1, lat);
    n_total++; if (!ok || b0 !== 8'h08 || b1 !== 8'h19) $display("FAIL drop_reply got %h %h want 08 19", b0, b1);
    else n_pass++;

    send_frame(8'h02, 8'h04);
    wait_sensor_start(s, c, 10);
    pulse_sensor_done(40'h28_00_19_00_41);
    wait_tx(s, c, 10);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_total++;
    if ({o_tx_data, o_tx_start, o_sensor_sel, o_sensor_start, o_busy, o_cont_active, o_drop} !== 19'd0)
      $display("FAIL midreset_outputs got %h want 0",
               {o_tx_data, o_tx_start, o_sensor_sel, o_sensor_start, o_busy, o_cont_active, o_drop});
    else n_pass++;
    send_frame(8'h05, 8'h05);
    wait_sensor_start(s, c, 10);
    n_total++; if (!s || o_sensor_sel !== 5'd5) $display("FAIL after_reset_sel got %0d want 5", o_sensor_sel); else n_pass++;
    pulse_sensor_done(40'h3C_00_16_00_52);
    get_reply(ok, b0, b1, lat);
    n_total++; if (!ok || b0 !== 8'h09 || b1 !== 8'h3C) $display("FAIL after_reset_reply got %h %h want 09 3c", b0, b1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_temp_read();
    test_checksum();
    test_bad_frames();
    test_timeout();
    test_rx_gap();
    test_continuous();
    test_drop_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached at cycle %0d", cyc_cnt);
    $fatal(1, "bench time limit");
  end

endmodule
